seg7_capture: RTL and testbench
===============================

// Module: seg7_capture
// PURPOSE
//  Receive-side counterpart of the two-digit 7-segment driver: monitors a time-multiplexed
//  active-low segment bus plus digit enables, decodes each digit pattern back to BCD,
//  reassembles the two-digit value and publishes it with a one-cycle valid strobe.
//  Used as a loopback checker/readback path for the display outputs (0..99 decoded).
// PARAMETERS
//  STABLE_CNT  4          cycles a pattern+enable must hold unchanged before it is sampled (>=1)
//  TIMEOUT     1000000    cycles without a completed frame before stale is asserted (>=2)
//  CNT_W       20         width of the timeout counter; must hold TIMEOUT
// PORTS
//  clk     in   1  system clock; all logic on rising edge
//  rst     in   1  synchronous, active-high reset
//  seg     in   8  segment bus, active-low, {a,b,c,d,e,f,g,dp}; dp (bit 0) ignored
//  an      in   2  digit enables, active-low; an[1]=tens, an[0]=units
//  value   out  7  last decoded value, tens*10+units (0..99)
//  valid   out  1  one-cycle pulse when value updates
//  changed out  1  one-cycle pulse coincident with valid when new value != previous value
//  err     out  1  one-cycle pulse on an illegal sampled pattern
//  stale   out  1  level: no frame completed within TIMEOUT cycles
// BEHAVIOUR
//  Reset: value=0, valid=0, changed=0, err=0, stale=0, FSM=HUNT, stability counter=0,
//   timeout counter=0, sync regs=all-ones (blank, no digit). Reset mid-frame drops partial frame.
//  Input sync: seg and an each pass a 2-flop synchroniser; all decisions use the 2nd stage.
//  Stability: counter clears whenever {seg[7:1],an} differs from the previous cycle, otherwise
//   increments, saturating at STABLE_CNT. A sample event fires exactly once, in the cycle the
//   counter reaches STABLE_CNT, and only if an is 2'b01 (tens) or 2'b10 (units); an=2'b11/2'b00
//   never samples. Input-to-sample latency = 2 (sync) + STABLE_CNT cycles.
//  Decode (seg[7:1], abcdefg, 0=lit): 0000001=0 1001111=1 0010010=2 0000110=3 1001100=4
//   0100100=5 0100000=6 0001111=7 0000000=8 0000100=9. 1111111 (blank) decodes to 0 on
//   tens only (leading-zero blanking); blank on units and any other pattern are illegal.
//  Illegal sample: err pulses next cycle, FSM returns to HUNT, partial frame discarded.
//  FSM (frame order tens then units):
//   HUNT:     legal tens sample -> latch tens, go GOT_TENS; units samples ignored.
//   GOT_TENS: legal units sample -> latch units, go EMIT; new legal tens sample -> overwrite
//             tens, stay.
//   EMIT:     one cycle: value<=tens*10+units (7-bit, max 99), valid=1, changed=1 iff result
//             != previous value, timeout counter cleared, stale<=0; -> HUNT.
//   valid/changed occur in the cycle after EMIT is entered (registered outputs).
//  Timeout: counter increments every cycle not in EMIT, saturates at TIMEOUT; stale=1 while
//   counter==TIMEOUT. stale clears on next valid. value holds while stale.
//  Simultaneous: a sample and a stability reset in the same cycle cannot occur (exclusive by
//   construction); err and valid are never asserted together.
// TESTING
//  1 Reset: hold rst 3 cycles with random seg/an -> all outputs 0, then first frame required
//    before any valid.
//  2 Drive tens '2'(an=01,seg=0010010x) 8 cycles, units '7'(an=10,seg=0001111x) 8 cycles,
//    STABLE_CNT=4 -> value=27, valid and changed pulse once each; repeat frame -> valid, no changed.
//  3 Tens blank (1111111x) then units '5' -> value=5; units blank -> err pulse, value unchanged.
//  4 Glitch: toggle seg every 2 cycles (< STABLE_CNT) -> no sample, no valid, no err.
//  5 Units first, then tens '3', tens '1', units '0' -> units ignored, tens overwritten, value=10.
//  6 TIMEOUT=50, no frames -> stale=1 at cycle 50 after reset; apply frame 30 -> valid, stale=0.

Source files
------------

// File: rtl/seg7_capture.sv
// seg7_capture: readback decoder for a two-digit, time-multiplexed, active-low
// 7-segment bus. Synchronises the bus, waits for each digit pattern to settle,
// decodes it to BCD, pairs tens with units and publishes the value with a
// one-cycle valid strobe. A stale flag reports a display that stopped refreshing.
//
// Handshake: none upstream (the display bus is free-running). Downstream,
// valid is a single-cycle strobe with no ready; value is held between strobes
// and is only meaningful in or after a valid cycle. changed only ever pulses
// together with valid. err pulses alone and never coincides with valid.
module seg7_capture #(
  parameter int STABLE_CNT = 4,
  parameter int TIMEOUT    = 1000000,
  parameter int CNT_W      = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seg,
  input  logic [1:0] an,
  output logic [6:0] value,
  output logic       valid,
  output logic       changed,
  output logic       err,
  output logic       stale
);

  localparam int SC_W = $clog2(STABLE_CNT + 1);

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    GOT_TENS = 2'd1,
    EMIT     = 2'd2
  } state_t;

  // Synchroniser stages (reset to blank segments, no digit enabled)
  logic [7:0] seg_s1_q, seg_s2_q;
  logic [1:0] an_s1_q, an_s2_q;

  // Stability tracking
  logic [8:0]      prev_q, prev_d;
  logic [SC_W-1:0] stab_q, stab_d;

  // Frame assembly and outputs
  state_t          state_q, state_d;
  logic [3:0]      tens_q, tens_d;
  logic [3:0]      units_q, units_d;
  logic [6:0]      value_q, value_d;
  logic            valid_q, valid_d;
  logic            changed_q, changed_d;
  logic            err_q, err_d;
  logic            stale_q, stale_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;

  // Combinational helpers
  logic [8:0] cur;
  logic       same;
  logic       sample;
  logic       is_tens;
  logic [3:0] dig;
  logic       dig_ok;
  logic       blank;
  logic       legal;
  logic [3:0] dval;
  logic [6:0] sum;

  // Two-flop synchronisers for the asynchronous display bus
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_s1_q <= 8'hFF;
      seg_s2_q <= 8'hFF;
      an_s1_q  <= 2'b11;
      an_s2_q  <= 2'b11;
    end else begin
      seg_s1_q <= seg;
      seg_s2_q <= seg_s1_q;
      an_s1_q  <= an;
      an_s2_q  <= an_s1_q;
    end
  end

  // Stability counter, sample qualification and segment decode
  always_comb begin
    cur    = {seg_s2_q[7:1], an_s2_q};
    same   = (cur == prev_q);
    prev_d = cur;
    stab_d = stab_q;
    if (!same) begin
      stab_d = '0;
    end else if (stab_q != SC_W'(STABLE_CNT)) begin
      stab_d = stab_q + SC_W'(1);
    end
    // Fires once: in the cycle the counter steps up to STABLE_CNT
    sample  = same && (stab_q == SC_W'(STABLE_CNT - 1)) &&
              ((an_s2_q == 2'b01) || (an_s2_q == 2'b10));
    is_tens = (an_s2_q == 2'b01);

    dig    = 4'd0;
    dig_ok = 1'b1;
    blank  = 1'b0;
    case (seg_s2_q[7:1])
      7'b0000001: dig = 4'd0;
      7'b1001111: dig = 4'd1;
      7'b0010010: dig = 4'd2;
      7'b0000110: dig = 4'd3;
      7'b1001100: dig = 4'd4;
      7'b0100100: dig = 4'd5;
      7'b0100000: dig = 4'd6;
      7'b0001111: dig = 4'd7;
      7'b0000000: dig = 4'd8;
      7'b0000100: dig = 4'd9;
      7'b1111111: begin
        dig_ok = 1'b0;
        blank  = 1'b1;
      end
      default:    dig_ok = 1'b0;
    endcase
    // A blank tens digit is leading-zero suppression; a blank units digit is not
    legal = is_tens ? (dig_ok || blank) : dig_ok;
    dval  = blank ? 4'd0 : dig;
  end

  // Frame FSM next-state, output strobes and timeout counter
  always_comb begin
    state_d   = state_q;
    tens_d    = tens_q;
    units_d   = units_q;
    value_d   = value_q;
    valid_d   = 1'b0;
    changed_d = 1'b0;
    err_d     = 1'b0;
    sum       = 7'(tens_q) * 7'd10 + 7'(units_q);

    case (state_q)
      HUNT, GOT_TENS: begin
        if (sample) begin
          if (!legal) begin
            err_d   = 1'b1;
            state_d = HUNT;
          end else if (is_tens) begin
            tens_d  = dval;
            state_d = GOT_TENS;
          end else if (state_q == GOT_TENS) begin
            units_d = dval;
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        value_d   = sum;
        valid_d   = 1'b1;
        changed_d = (sum != value_q);
        state_d   = HUNT;
      end
      default: state_d = HUNT;
    endcase

    if (state_q == EMIT) begin
      tmo_d = '0;
    end else if (tmo_q == CNT_W'(TIMEOUT)) begin
      tmo_d = tmo_q;
    end else begin
      tmo_d = tmo_q + CNT_W'(1);
    end
    stale_d = (tmo_d == CNT_W'(TIMEOUT));
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q    <= 9'h1FF;
      stab_q    <= '0;
      state_q   <= HUNT;
      tens_q    <= 4'd0;
      units_q   <= 4'd0;
      value_q   <= 7'd0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      err_q     <= 1'b0;
      stale_q   <= 1'b0;
      tmo_q     <= '0;
    end else begin
      prev_q    <= prev_d;
      stab_q    <= stab_d;
      state_q   <= state_d;
      tens_q    <= tens_d;
      units_q   <= units_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
      err_q     <= err_d;
      stale_q   <= stale_d;
      tmo_q     <= tmo_d;
    end
  end

  assign value   = value_q;
  assign valid   = valid_q;
  assign changed = changed_q;
  assign err     = err_q;
  assign stale   = stale_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed testbench for seg7_capture: drives digit patterns on the muxed bus,
// scores published values against an expected queue and counts strobes.
module tb_seg7_capture;

  logic       clk;
  logic       rst;
  logic [7:0] seg;
  logic [1:0] an;
  logic [6:0] value;
  logic       valid;
  logic       changed;
  logic       err;
  logic       stale;

  int n_cmp = 0;
  int n_bad = 0;
  int valid_cnt = 0;
  int changed_cnt = 0;
  int err_cnt = 0;
  logic [6:0] exp_q[$];

  localparam int BLANK = 10;

  seg7_capture #(.STABLE_CNT(4), .TIMEOUT(50), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .seg(seg), .an(an), .value(value),
    .valid(valid), .changed(changed), .err(err), .stale(stale)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Hand-written active-low patterns {abcdefg, dp}, dp left off
  function automatic logic [7:0] segb(input int d);
    logic [6:0] p;
    case (d)
      0: p = 7'b0000001;
      1: p = 7'b1001111;
      2: p = 7'b0010010;
      3: p = 7'b0000110;
      4: p = 7'b1001100;
      5: p = 7'b0100100;
      6: p = 7'b0100000;
      7: p = 7'b0001111;
      8: p = 7'b0000000;
      9: p = 7'b0000100;
      default: p = 7'b1111111;
    endcase
    return {p, 1'b1};
  endfunction

  // Driver tasks (called on the falling edge)
  task automatic drive(input logic [1:0] a, input int d, input int n);
    an  = a;
    seg = segb(d);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    an  = 2'b11;
    seg = 8'hFF;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input int t, input int u);
    drive(2'b01, t, 8);
    drive(2'b10, u, 8);
    idle(8);
  endtask

  // Scoreboard: every valid must match the next expected value
  always @(negedge clk) begin
    if (!rst) begin
      if (valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
        else check("value_at_valid", int'(value), int'(exp_q.pop_front()));
      end
      if (changed) begin
        changed_cnt++;
        if (!valid) check("changed_without_valid", 1, 0);
      end
      if (err) begin
        err_cnt++;
        if (valid) check("err_with_valid", 1, 0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    seg = 8'hFF;
    an  = 2'b11;
    // Reset with random bus activity
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      seg = 8'($urandom_range(0, 255));
      an  = 2'($urandom_range(0, 3));
    end
    check("rst_value", int'(value), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_changed", int'(changed), 0);
    check("rst_err", int'(err), 0);
    check("rst_stale", int'(stale), 0);
    rst = 1'b0;

    // Idle after reset: stale rises at cycle 50
    idle(45);
    check("stale_before_timeout", int'(stale), 0);
    idle(10);
    check("stale_after_timeout", int'(stale), 1);
    check("no_valid_before_frame", valid_cnt, 0);

    // Frame 30 clears stale
    exp_q.push_back(7'd30);
    frame(3, 0);
    check("stale_cleared", int'(stale), 0);
    check("valid_cnt_30", valid_cnt, 1);
    check("changed_cnt_30", changed_cnt, 1);

    // Frame 27, then the same frame again
    exp_q.push_back(7'd27);
    frame(2, 7);
    check("valid_cnt_27", valid_cnt, 2);
    check("changed_cnt_27", changed_cnt, 2);
    exp_q.push_back(7'd27);
    frame(2, 7);
    check("valid_cnt_27_rep", valid_cnt, 3);
    check("changed_cnt_27_rep", changed_cnt, 2);
    check("value_27", int'(value), 27);

    // Blank tens is zero; blank units is an error
    exp_q.push_back(7'd5);
    frame(BLANK, 5);
    check("value_blank_tens", int'(value), 5);
    check("valid_cnt_5", valid_cnt, 4);
    frame(0, BLANK);
    check("err_cnt_blank_units", err_cnt, 1);
    check("valid_cnt_after_err", valid_cnt, 4);
    check("value_after_err", int'(value), 5);

    // Glitching bus shorter than the stability window
    for (int i = 0; i < 10; i++) begin
      drive(2'b01, 2, 2);
      drive(2'b01, 3, 2);
    end
    idle(8);
    check("valid_cnt_glitch", valid_cnt, 4);
    check("err_cnt_glitch", err_cnt, 1);

    // Units before tens ignored; later tens overwrites earlier
    exp_q.push_back(7'd10);
    drive(2'b10, 4, 8);
    drive(2'b01, 3, 8);
    drive(2'b01, 1, 8);
    drive(2'b10, 0, 8);
    idle(8);
    check("value_overwrite", int'(value), 10);
    check("valid_cnt_overwrite", valid_cnt, 5);
    check("changed_cnt_overwrite", changed_cnt, 4);

    // Reset mid-frame drops the partial frame
    drive(2'b01, 9, 8);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    drive(2'b10, 6, 8);
    idle(8);
    check("value_after_midreset", int'(value), 0);
    check("valid_cnt_midreset", valid_cnt, 5);
    check("err_cnt_midreset", err_cnt, 1);

    check("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
